csr_access_master: RTL and testbench
====================================

// Module: csr_access_master
// PURPOSE
//  Initiator side of the core CSR bus: converts one abstract CSR command
//  (read / write / set / clear, e.g. from the debug module) into the CSR
//  check/read/write sequence consumed by CSR responders (PMU, trap, MMU CSRs).
//  Collects rdata/hit/ill, applies read-only checking, returns one response
//  per command over a valid/ready handshake. One command in flight.
// PARAMETERS
//  XLEN      64  CSR data width
//  RO_CHK_EN 1   1: flag writes to addr[11:10]==2'b11 as error, no write issued
// PORTS
//  clk_free    in   1     clock
//  rst         in   1     synchronous reset, active-high
//  cmd_valid   in   1     command request
//  cmd_ready   out  1     command accept (high only in IDLE)
//  cmd_op      in   2     00 read, 01 write, 10 set, 11 clear
//  cmd_addr    in   12    CSR address
//  cmd_wdata   in   XLEN  write/set/clear operand
//  rsp_valid   out  1     response available
//  rsp_ready   in   1     response consumed
//  rsp_rdata   out  XLEN  CSR value before any write; 0 on error
//  rsp_err     out  2     00 ok, 01 illegal, 10 read-only write, 11 no hit
//  csr_rd_chk  out  1     check strobe, read access
//  csr_wr_chk  out  1     check strobe, write access
//  csr_wr      out  1     write strobe
//  csr_waddr   out  12    write/check address
//  csr_raddr   out  12    read address
//  csr_sdata   out  XLEN  bits to set
//  csr_cdata   out  XLEN  bits to clear
//  csr_rdata   in   XLEN  responder read data (combinational on raddr)
//  csr_hit     in   1     responder claims address
//  csr_ill     in   1     responder flags illegal access
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1 in cycle after reset; rsp_valid, rsp_err,
//   rsp_rdata, all csr_* outputs 0. csr_wr gated by ~rst combinationally.
//  FSM IDLE->CHK->(WR)->RSP->IDLE. Accept on cmd_valid&&cmd_ready (cycle T);
//   op/addr/wdata registered.
//  CHK (T+1): csr_raddr=csr_waddr=addr; csr_rd_chk=1; csr_wr_chk=(op!=00).
//   Sample csr_rdata, csr_hit, csr_ill. Error priority: ill(01) >
//   RO write(10, op!=00 && RO_CHK_EN && addr[11:10]==11) > ~hit(11).
//   Error or op==00 -> RSP; else -> WR.
//  WR (T+2): csr_wr=1 exactly one cycle, waddr=addr; chk strobes 0.
//   write: sdata=wdata, cdata=~wdata; set: sdata=wdata, cdata=0;
//   clear: sdata=0, cdata=wdata. sdata/cdata 0 outside WR.
//  RSP: rsp_valid=1 (T+2 read/error, T+3 write), rdata/err stable until
//   rsp_valid&&rsp_ready; then IDLE, cmd_ready=1 next cycle (no same-cycle
//   re-accept). cmd_ready=0 in CHK/WR/RSP.
//  Set/clear with wdata=0 still issue csr_wr. Read never issues csr_wr.
//  csr_raddr/csr_waddr = 0 in IDLE and RSP.
//  rst in any state: IDLE next edge, command dropped, no response, no
//   csr_wr in the rst cycle.
// TESTING
//  read 0xF14, model rdata=3 hit=1 -> rsp at T+2 rdata=3 err=00, csr_wr never 1
//  write 0x306 wdata=5, old=2 -> T+2 csr_wr=1 sdata=5 cdata=~5; T+3 rdata=2 err=00
//  set 0x306 wdata=0x8 / clear wdata=0x1 -> sdata=8,cdata=0 / sdata=0,cdata=1
//  write 0xC00 hit=1 -> err=10, no csr_wr; read 0x7C0 hit=0 -> err=11 rdata=0
//  csr_ill=1 and hit=0 on write 0x320 -> err=01 (ill wins), no csr_wr
//  rsp_ready low 3 cycles -> rsp held stable, cmd_ready=0; rst during WR -> csr_wr=0, IDLE

Source files
------------

// File: rtl/csr_access_master.sv
// Initiator for the core CSR bus: runs one abstract read/write/set/clear command
// through a check/read/write sequence against CSR responders and returns one response.
module csr_access_master #(
  parameter int XLEN      = 64,
  parameter bit RO_CHK_EN = 1'b1
) (
  input  logic            clk_free,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [11:0]     cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_err,
  output logic            csr_rd_chk,
  output logic            csr_wr_chk,
  output logic            csr_wr,
  output logic [11:0]     csr_waddr,
  output logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_sdata,
  output logic [XLEN-1:0] csr_cdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_hit,
  input  logic            csr_ill
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHK  = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ILL   = 2'b01;
  localparam logic [1:0] ERR_RO    = 2'b10;
  localparam logic [1:0] ERR_NOHIT = 2'b11;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;

  logic            ro_write;
  logic [1:0]      chk_err;

  assign ro_write = (op_q != OP_READ) && RO_CHK_EN && (addr_q[11:10] == 2'b11);

  // Illegal beats read-only, which beats a missing responder.
  always_comb begin
    chk_err = ERR_OK;
    if (csr_ill) begin
      chk_err = ERR_ILL;
    end else if (ro_write) begin
      chk_err = ERR_RO;
    end else if (!csr_hit) begin
      chk_err = ERR_NOHIT;
    end
  end

  always_ff @(posedge clk_free) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = ERR_OK;
    csr_rd_chk = 1'b0;
    csr_wr_chk = 1'b0;
    csr_wr     = 1'b0;
    csr_waddr  = '0;
    csr_raddr  = '0;
    csr_sdata  = '0;
    csr_cdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        csr_raddr  = addr_q;
        csr_waddr  = addr_q;
        csr_rd_chk = 1'b1;
        csr_wr_chk = (op_q != OP_READ);
        err_d      = chk_err;
        rdata_d    = (chk_err == ERR_OK) ? csr_rdata : '0;
        state_d    = ((chk_err != ERR_OK) || (op_q == OP_READ)) ? ST_RSP : ST_WR;
      end
      ST_WR: begin
        // Reset must suppress the strobe within the same cycle.
        csr_wr    = ~rst;
        csr_waddr = addr_q;
        if (op_q == OP_WRITE) begin
          csr_sdata = wdata_q;
          csr_cdata = ~wdata_q;
        end else if (op_q == OP_SET) begin
          csr_sdata = wdata_q;
        end else begin
          csr_cdata = wdata_q;
        end
        state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_master.sv
// Directed, table-driven bench for csr_access_master with a behavioural CSR responder.
module tb_csr_access_master;
  localparam int XLEN = 64;

  logic            clk_free = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [11:0]     cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic [1:0]      rsp_err;
  logic            csr_rd_chk, csr_wr_chk, csr_wr;
  logic [11:0]     csr_waddr, csr_raddr;
  logic [XLEN-1:0] csr_sdata, csr_cdata, csr_rdata;
  logic            csr_hit, csr_ill;

  // Responder model: returns its value only when the read address matches.
  logic [11:0]     m_addr;
  logic [XLEN-1:0] m_rdata;
  logic            m_hit, m_ill;
  assign csr_rdata = (csr_raddr == m_addr) ? m_rdata : '0;
  assign csr_hit   = m_hit;
  assign csr_ill   = m_ill;

  always #5 clk_free = ~clk_free;

  csr_access_master #(.XLEN(XLEN), .RO_CHK_EN(1'b1)) dut (
    .clk_free(clk_free), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .csr_rd_chk(csr_rd_chk), .csr_wr_chk(csr_wr_chk), .csr_wr(csr_wr),
    .csr_waddr(csr_waddr), .csr_raddr(csr_raddr),
    .csr_sdata(csr_sdata), .csr_cdata(csr_cdata),
    .csr_rdata(csr_rdata), .csr_hit(csr_hit), .csr_ill(csr_ill)
  );

  typedef struct {
    logic [1:0]      op;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] old;
    logic            hit;
    logic            ill;
    int              stall;
    logic [XLEN-1:0] exp_rdata;
    logic [1:0]      exp_err;
    logic            exp_wr;
    logic [XLEN-1:0] exp_s;
    logic [XLEN-1:0] exp_c;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_free);
    @(negedge clk_free);
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] wdata);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_wdata = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    m_addr  = v.addr;
    m_rdata = v.old;
    m_hit   = v.hit;
    m_ill   = v.ill;
    issue(v.op, v.addr, v.wdata);
    // T+1: check phase
    chk("chk_rd_chk", {63'd0, csr_rd_chk}, 64'd1);
    chk("chk_wr_chk", {63'd0, csr_wr_chk}, {63'd0, v.op != 2'b00});
    chk("chk_raddr", {52'd0, csr_raddr}, {52'd0, v.addr});
    chk("chk_waddr", {52'd0, csr_waddr}, {52'd0, v.addr});
    chk("chk_no_wr", {63'd0, csr_wr}, 64'd0);
    chk("chk_sdata0", csr_sdata, 64'd0);
    chk("chk_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    step();
    if (v.exp_wr) begin
      chk("wr_strobe", {63'd0, csr_wr}, 64'd1);
      chk("wr_waddr", {52'd0, csr_waddr}, {52'd0, v.addr});
      chk("wr_sdata", csr_sdata, v.exp_s);
      chk("wr_cdata", csr_cdata, v.exp_c);
      chk("wr_no_chk", {62'd0, csr_rd_chk, csr_wr_chk}, 64'd0);
      chk("wr_no_rsp", {63'd0, rsp_valid}, 64'd0);
      step();
    end
    // Response, held for v.stall extra cycles with rsp_ready low
    for (int s = 0; s <= v.stall; s++) begin
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_err", {62'd0, rsp_err}, {62'd0, v.exp_err});
      chk("rsp_no_wr", {63'd0, csr_wr}, 64'd0);
      chk("rsp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("rsp_raddr0", {52'd0, csr_raddr}, 64'd0);
      if (s == v.stall) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    $display("vec %0d op=%0d addr=%03h rdata=%0h err=%0d wr=%0d", i, v.op, v.addr,
             v.exp_rdata, v.exp_err, v.exp_wr);
  endtask

  initial begin
    //          op     addr     wdata   old        hit   ill  stall exp_rdata  err    wr    sdata  cdata
    vecs[0] = '{2'b00, 12'hF14, 64'h0,  64'h3,     1'b1, 1'b0, 0, 64'h3,     2'b00, 1'b0, 64'h0, 64'h0};
    vecs[1] = '{2'b01, 12'h306, 64'h5,  64'h2,     1'b1, 1'b0, 3, 64'h2,     2'b00, 1'b1, 64'h5,
                64'hFFFF_FFFF_FFFF_FFFA};
    vecs[2] = '{2'b10, 12'h306, 64'h8,  64'h2,     1'b1, 1'b0, 0, 64'h2,     2'b00, 1'b1, 64'h8, 64'h0};
    vecs[3] = '{2'b11, 12'h306, 64'h1,  64'hA,     1'b1, 1'b0, 0, 64'hA,     2'b00, 1'b1, 64'h0, 64'h1};
    vecs[4] = '{2'b01, 12'hC00, 64'h9,  64'h7,     1'b1, 1'b0, 0, 64'h0,     2'b10, 1'b0, 64'h0, 64'h0};
    vecs[5] = '{2'b00, 12'h7C0, 64'h0,  64'h55,    1'b0, 1'b0, 0, 64'h0,     2'b11, 1'b0, 64'h0, 64'h0};
    vecs[6] = '{2'b01, 12'h320, 64'h4,  64'h6,     1'b0, 1'b1, 2, 64'h0,     2'b01, 1'b0, 64'h0, 64'h0};
    vecs[7] = '{2'b10, 12'h300, 64'h0,  64'h11,    1'b1, 1'b0, 0, 64'h11,    2'b00, 1'b1, 64'h0, 64'h0};
    vecs[8] = '{2'b00, 12'hC00, 64'h0,  64'h1234,  1'b1, 1'b0, 0, 64'h1234,  2'b00, 1'b0, 64'h0, 64'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    m_addr = '0; m_rdata = '0; m_hit = 1'b0; m_ill = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp", {62'd0, rsp_err} | rsp_rdata, 64'd0);
    chk("reset_csr", {59'd0, csr_rd_chk, csr_wr_chk, csr_wr, |csr_waddr, |csr_raddr}, 64'd0);
    $display("reset done");

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset asserted while a write sits in WR: strobe must drop at once, command is lost.
    m_addr = 12'h306; m_rdata = 64'h2; m_hit = 1'b1; m_ill = 1'b0;
    issue(2'b01, 12'h306, 64'h5);
    step();
    chk("rstwr_pre_wr", {63'd0, csr_wr}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_wr_gated", {63'd0, csr_wr}, 64'd0);
    step();
    rst = 1'b0;
    chk("rstwr_idle_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rstwr_no_rsp", {63'd0, rsp_valid}, 64'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstwr_still_idle", {62'd0, rsp_valid, csr_wr}, 64'd0);
    end
    rsp_ready = 1'b0;
    $display("reset during write: dropped");

    // Back-to-back: a command must complete normally after the dropped one.
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
